energy_frame_transmitter: RTL
=============================

// Module: energy_frame_transmitter
// PURPOSE
// - Transmit end of the energy-data link: buffers converter samples, packs them into framed
//   byte packets, and streams them out over a valid/ready byte interface to data_collection logic.
// - Sits between the power converter sample tap and the IO-side data path.
// - Every frame has the same fixed layout: SYNC, SEQ, FRAME_LEN payload bytes, CSUM.
// PARAMETERS
// - FIFO_DEPTH  8      sample FIFO entries; power of 2, >= FRAME_LEN
// - FRAME_LEN   4      payload samples per frame, 1..FIFO_DEPTH
// - SYNC_BYTE   8'hA5  first byte of every frame
// PORTS
// - clk           in   1                 single clock, rising edge
// - reset         in   1                 asynchronous, active-high
// - sample_in     in   8                 converter sample
// - sample_valid  in   1                 push strobe for sample_in
// - tx_data       out  8                 frame byte
// - tx_valid      out  1                 tx_data is valid
// - tx_ready      in   1                 sink accepts the byte when tx_valid && tx_ready
// - tx_sof        out  1                 high with the SYNC byte
// - tx_eof        out  1                 high with the CSUM byte
// - fifo_level    out  $clog2(DEPTH)+1   current FIFO occupancy
// - overflow      out  1                 sticky flag: a sample was dropped
// - frame_count   out  8                 number of frames completed, wraps 255->0
// BEHAVIOUR
// - Interface: one clock; reset is asynchronous and active-high.
// - Reset values: tx_data=0, tx_valid=0, tx_sof=0, tx_eof=0, fifo_level=0, overflow=0,
//   frame_count=0, SEQ counter=0, checksum=0, FSM=IDLE.
// - Push:
//   - Accepted when sample_valid=1 and the FIFO is not full, with "full" evaluated on the
//     registered level at the start of the cycle.
//   - A pop in the same cycle does not free a slot for the push.
//   - A rejected push sets overflow. overflow clears only on reset.
// - Level update:
//   - Same-cycle push and pop: level is unchanged.
//   - Pointers wrap modulo FIFO_DEPTH.
// - FSM states and transitions:
//   - IDLE -> SYNC when fifo_level >= FRAME_LEN (registered). tx_valid goes high on the
//     next cycle, so latency from the qualifying level to SYNC on the bus is 1 clk.
//   - SYNC: tx_data=SYNC_BYTE, tx_sof=1. On accept -> SEQ.
//   - SEQ: tx_data=seq counter. On accept -> PAYLOAD, and checksum loads the SEQ value.
//   - PAYLOAD: tx_data=FIFO head. On accept, pop one entry and add it to the checksum.
//     After FRAME_LEN accepts -> CSUM.
//   - CSUM: tx_data=checksum, tx_eof=1. On accept: seq+1, frame_count+1, then go to IDLE.
//     IDLE immediately re-evaluates the level, so back-to-back frames have 1 idle cycle.
// - Checksum: 8-bit modular sum of SEQ plus all payload bytes. Carries are discarded.
//   SYNC is excluded.
// - Handshake rules:
//   - While tx_valid && !tx_ready, tx_data, tx_sof and tx_eof are held stable.
//   - tx_valid never drops before the byte is accepted.
//   - tx_valid is 0 in IDLE.
//   - A byte transfers only when tx_valid && tx_ready are both high on the same clock edge.
// - Frame commitment: a frame starts only when all FRAME_LEN samples are buffered, so
//   PAYLOAD never stalls on an empty FIFO. Pushes during a frame are allowed.
// - Wrap-around: seq and frame_count wrap 255->0 with no flag.
// - Reset mid-frame: the frame is aborted immediately, with no EOF. FIFO contents are
//   discarded and all counters clear.
// TESTING
// - Push 4 samples 0x10,0x20,0x30,0x40, hold tx_ready=1 -> expected bytes:
//   A5,00,10,20,30,40,A0. SOF on A5, EOF on A0, frame_count=1.
// - Same 4 samples with tx_ready toggling 1/0 every clk -> same byte sequence, each byte
//   held stable while stalled, no duplicates or drops.
// - Payload FF,FF,FF,FF with SEQ=0x03 -> CSUM=0xFF (sum is 0x3FF truncated to 8 bits).
//   Frame 256 sends SEQ=00 and frame_count reads 0.
// - Hold tx_ready=0 and push 9 samples (DEPTH=8) -> fifo_level=8, overflow=1, 9th sample
//   absent from the stream. Push at full with a same-cycle pop is still rejected.
// - Assert reset during PAYLOAD byte 2 -> outputs return to reset values with no tx_eof.
//   After release, 4 new samples produce a frame with SEQ=00.
// - Push 8 samples with tx_ready=1 -> two back-to-back frames, SEQ 00 then 01,
//   1 idle cycle between CSUM and the next SYNC.

Source files
------------

// File: rtl/energy_frame_transmitter.sv
// Transmit end of the energy-data link. Buffers converter samples in a small FIFO and streams
// fixed-layout frames (SYNC, SEQ, payload, CSUM) over a valid/ready byte interface.
module energy_frame_transmitter #(
  parameter int         FIFO_DEPTH = 8,
  parameter int         FRAME_LEN  = 4,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    sample_in,
  input  logic                          sample_valid,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic                          tx_sof,
  output logic                          tx_eof,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [7:0]                    frame_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] FLEN_L  = LW'(FRAME_LEN);
  localparam logic [LW-1:0] LAST_L  = LW'(FRAME_LEN - 1);

  typedef enum logic [2:0] {IDLE, SYNC, SEQ, PAYLOAD, CSUM} state_e;

  state_e          state_q, state_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q;
  logic [LW-1:0]   pcnt_q;
  logic [7:0]      seq_q, csum_q, fc_q;
  logic            ovf_q;

  logic            full, push, accept, pop;
  logic [7:0]      head;

  // Full is judged on the registered level, so a same-cycle pop never makes room for a push.
  assign full   = (level_q == DEPTH_L);
  assign push   = sample_valid && !full;
  assign accept = tx_valid && tx_ready;
  assign pop    = accept && (state_q == PAYLOAD);
  assign head   = mem_q[rd_ptr_q];

  assign fifo_level  = level_q;
  assign overflow    = ovf_q;
  assign frame_count = fc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    tx_valid = 1'b0;
    tx_data  = '0;
    tx_sof   = 1'b0;
    tx_eof   = 1'b0;
    case (state_q)
      IDLE: begin
        if (level_q >= FLEN_L) state_d = SYNC;
      end
      SYNC: begin
        tx_valid = 1'b1;
        tx_data  = SYNC_BYTE;
        tx_sof   = 1'b1;
        if (tx_ready) state_d = SEQ;
      end
      SEQ: begin
        tx_valid = 1'b1;
        tx_data  = seq_q;
        if (tx_ready) state_d = PAYLOAD;
      end
      PAYLOAD: begin
        tx_valid = 1'b1;
        tx_data  = head;
        if (tx_ready && (pcnt_q == LAST_L)) state_d = CSUM;
      end
      CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum_q;
        tx_eof   = 1'b1;
        if (tx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Storage needs no reset: pointers and level define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= sample_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      if (sample_valid && full) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_q  <= '0;
      csum_q <= '0;
      fc_q   <= '0;
      pcnt_q <= '0;
    end else begin
      if (accept && (state_q == SEQ)) begin
        csum_q <= seq_q;
        pcnt_q <= '0;
      end
      if (pop) begin
        csum_q <= csum_q + head;
        pcnt_q <= pcnt_q + LW'(1);
      end
      if (accept && (state_q == CSUM)) begin
        seq_q <= seq_q + 8'd1;
        fc_q  <= fc_q + 8'd1;
      end
    end
  end

endmodule
